cpu_sequencer: RTL and testbench

Program sequencer for the 4-bit CPU core. It holds a 16-entry program store and steps a program counter through it. Each stored 11-bit instruction is issued to the core's instruction input for exactly one cycle, followed by a fixed settle window of NOP cycles so the registered ALU and synchronous RAM finish before the next issue. It supports free-run, single-step, abort and a done indication, and sits directly upstream of the core's instruction port.

---
 rtl/cpu_seq_pkg.sv | 25 ++
 rtl/cpu_sequencer_if.sv | 38 +++
 rtl/cpu_seq_prog_store.sv | 26 ++
 rtl/cpu_sequencer.sv | 123 ++++++++++++
 tb/tb_cpu_sequencer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU program sequencer: FSM state codes,
// program-word field positions and program-store geometry.
package cpu_seq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam int PW_LAST_BIT  = 11;
  localparam int PW_INSTR_MSB = 10;
  localparam int PW_W         = PW_LAST_BIT + 1;
  localparam int PROG_DEPTH   = 16;
  localparam int PC_W         = $clog2(PROG_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_HOLD  = ST_HOLD,
    S_DONE  = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bus between the sequencer and its controller/core.
// The loop input exists only when CPU_SEQ_LOOP_EN is defined.
interface cpu_sequencer_if;
  import cpu_seq_pkg::*;

  logic                    prog_we;
  logic [PC_W-1:0]         prog_addr;
  logic [PW_W-1:0]         prog_wdata;
  logic                    start;
  logic                    step_mode;
  logic                    step;
  logic                    abort;
`ifdef CPU_SEQ_LOOP_EN
  logic                    loop;
`endif
  logic [PW_INSTR_MSB:0]   instruction;
  logic                    issue_valid;
  logic [PC_W-1:0]         pc;
  logic                    busy;
  logic                    done;

  modport master (
`ifdef CPU_SEQ_LOOP_EN
    output loop,
`endif
    output prog_we, prog_addr, prog_wdata, start, step_mode, step, abort,
    input  instruction, issue_valid, pc, busy, done
  );

  modport slave (
`ifdef CPU_SEQ_LOOP_EN
    input  loop,
`endif
    input  prog_we, prog_addr, prog_wdata, start, step_mode, step, abort,
    output instruction, issue_valid, pc, busy, done
  );

endinterface

// File: rtl/cpu_seq_prog_store.sv
// 16x12 program store: qualified synchronous write, combinational read.
// Contents are deliberately not reset so a program survives a sequencer reset.
module cpu_seq_prog_store
  import cpu_seq_pkg::*;
(
  input  logic            clk,
  input  logic            we,
  input  logic            wr_qual,
  input  logic [PC_W-1:0] waddr,
  input  logic [PW_W-1:0] wdata,
  input  logic [PC_W-1:0] raddr,
  output logic [PW_W-1:0] rdata
);

  logic [PW_W-1:0] mem [PROG_DEPTH];

  // Accept a write only when the sequencer says the store is not in use
  always_ff @(posedge clk) begin
    if (we && wr_qual) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_sequencer.sv
// Program sequencer: issues one stored word per issue cycle, then a settle
// window of NOPs. Optional wrap-around at program end with CPU_SEQ_LOOP_EN.
module cpu_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned           SETTLE_CYCLES = 2,
  parameter logic [PW_INSTR_MSB:0] NOP_INSTR     = 11'h000
) (
  input logic            clk,
  input logic            reset_n,
  cpu_sequencer_if.slave bus
);

  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_LAST     = PC_W'(PROG_DEPTH - 1);

  seq_state_t            state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [PW_INSTR_MSB:0] instr_q, instr_d;
  logic                  last_q, last_d;
  logic                  at_end;
  logic                  loop_en;
  logic                  wr_qual;
  logic                  issuing;
  logic [PW_W-1:0]       rd_data;

`ifdef CPU_SEQ_LOOP_EN
  assign loop_en = bus.loop;
`else
  assign loop_en = 1'b0;
`endif

  // The store may only change while no program is running and no run starts
  assign wr_qual = ((state_q == S_IDLE) || (state_q == S_DONE)) && !bus.start;

  // The last flag of the issued word is latched so one read port suffices
  assign at_end = last_q || (pc_q == PC_LAST);

  cpu_seq_prog_store u_store (
    .clk     (clk),
    .we      (bus.prog_we),
    .wr_qual (wr_qual),
    .waddr   (bus.prog_addr),
    .wdata   (bus.prog_wdata),
    .raddr   (pc_d),
    .rdata   (rd_data)
  );

  // Next-state, next-pc and settle-counter logic; abort beats everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (bus.abort) begin
      state_d = S_IDLE;
      pc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d = S_ISSUE;
            pc_d    = '0;
          end
        end
        S_ISSUE: begin
          state_d = S_WAIT;
          cnt_d   = SETTLE_LOAD;
        end
        S_WAIT: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (at_end && !loop_en) begin
            state_d = S_DONE;
          end else begin
            pc_d    = at_end ? '0 : pc_q + 1'b1;
            state_d = bus.step_mode ? S_HOLD : S_ISSUE;
          end
        end
        S_HOLD: begin
          if (bus.step || !bus.step_mode) begin
            state_d = S_ISSUE;
          end
        end
        default: begin
          state_d = S_IDLE;
          pc_d    = '0;
        end
      endcase
    end
  end

  // The word for the issue cycle is read at the address that issue will use
  always_comb begin
    issuing = (state_d == S_ISSUE);
    instr_d = issuing ? rd_data[PW_INSTR_MSB:0] : NOP_INSTR;
    last_d  = issuing ? rd_data[PW_LAST_BIT]    : last_q;
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= 4'd0;
      instr_q <= NOP_INSTR;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      last_q  <= last_d;
    end
  end

  assign bus.instruction = instr_q;
  assign bus.issue_valid = (state_q == S_ISSUE);
  assign bus.pc          = pc_q;
  assign bus.busy        = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_HOLD);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. A cycle-level behavioural model
// (issue age, hold flag, run status) is compared on every falling edge,
// and directed scenarios pin it with literal expectations.
module tb_cpu_sequencer;
  import cpu_seq_pkg::*;

  localparam int          SC  = 2;
  localparam logic [10:0] NOP = 11'h000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  cpu_sequencer_if bus();

  cpu_sequencer #(.SETTLE_CYCLES(SC), .NOP_INSTR(NOP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Shared comparison: one FAIL line per mismatch
  task automatic cmp(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_RUN, M_DONE} m_run_t;
  logic [11:0] m_mem [16];
  m_run_t      m_run = M_IDLE;
  int          m_age = 0;
  bit          m_hold = 0;
  int          m_pc = 0;
  logic [10:0] m_instr = NOP;
  bit          m_valid = 0;
  bit          loop_now;
  bit          end_c;

  task model_issue();
    m_age   = 0;
    m_instr = m_mem[m_pc][10:0];
  endtask

  // Advance the model on every rising edge from the inputs held since the last fall
  always @(posedge clk) begin
    cyc++;
`ifdef CPU_SEQ_LOOP_EN
    loop_now = bus.loop;
`else
    loop_now = 1'b0;
`endif
    if (!reset_n) begin
      m_run = M_IDLE; m_pc = 0; m_hold = 0; m_age = 0; m_instr = NOP; m_valid = 1;
    end else if (m_valid) begin
      if (bus.prog_we && m_run != M_RUN && !bus.start)
        m_mem[bus.prog_addr] = bus.prog_wdata;
      m_instr = NOP;
      if (bus.abort) begin
        m_run = M_IDLE; m_pc = 0; m_hold = 0;
      end else if (m_run != M_RUN) begin
        if (bus.start) begin
          m_run = M_RUN; m_pc = 0; m_hold = 0; model_issue();
        end
      end else if (m_hold) begin
        if (bus.step || !bus.step_mode) begin
          m_hold = 0; model_issue();
        end
      end else if (m_age < SC) begin
        m_age++;
      end else begin
        end_c = m_mem[m_pc][11] || (m_pc == 15);
        if (end_c && !loop_now) begin
          m_run = M_DONE;
        end else begin
          m_pc = end_c ? 0 : m_pc + 1;
          if (bus.step_mode) m_hold = 1;
          else model_issue();
        end
      end
    end
  end

  // Compare DUT against the model on each falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      cmp("model_instruction", 16'(bus.instruction), 16'(m_instr));
      cmp("model_issue_valid", 16'(bus.issue_valid), 16'(m_run == M_RUN && !m_hold && m_age == 0));
      cmp("model_pc",          16'(bus.pc),          16'(m_pc));
      cmp("model_busy",        16'(bus.busy),        16'(m_run == M_RUN));
      cmp("model_done",        16'(bus.done),        16'(m_run == M_DONE));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [11:0] wd,
                               input logic st, input logic sm, input logic sp, input logic ab);
    bus.prog_we = we; bus.prog_addr = addr; bus.prog_wdata = wd;
    bus.start = st; bus.step_mode = sm; bus.step = sp; bus.abort = ab;
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input logic sm);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'd0, 12'd0, 1'b0, sm, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string nm, input logic [10:0] ei, input logic eiv,
                             input logic [3:0] ep, input logic eb, input logic ed);
    cmp({nm, "_instr"}, 16'(bus.instruction), 16'(ei));
    cmp({nm, "_iv"},    16'(bus.issue_valid), 16'(eiv));
    cmp({nm, "_pc"},    16'(bus.pc),          16'(ep));
    cmp({nm, "_busy"},  16'(bus.busy),        16'(eb));
    cmp({nm, "_done"},  16'(bus.done),        16'(ed));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n_issue;
    int n_extra;
    logic [10:0] last_word;

    bus.prog_we = 0; bus.prog_addr = 0; bus.prog_wdata = 0;
    bus.start = 0; bus.step_mode = 0; bus.step = 0; bus.abort = 0;
`ifdef CPU_SEQ_LOOP_EN
    bus.loop = 0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset", NOP, 0, 4'd0, 0, 0);
    reset_n = 1'b1;

    // Full 16-entry program without last flags: runs off the end at pc 15
    $display("[TB] full program, implicit end");
    for (int i = 0; i < 16; i++) applyStimulus(1, 4'(i), 12'h100 + 12'(i), 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("full_first", 11'h100, 1, 4'd0, 1, 0);
    n_issue = 1; last_word = bus.instruction;
    for (int i = 0; i < 100 && !bus.done; i++) begin
      idle_cycles(1, 0);
      if (bus.issue_valid) begin n_issue++; last_word = bus.instruction; end
    end
    cmp("full_reached_done", 16'(bus.done), 16'd1);
    cmp("full_issue_count", 16'(n_issue), 16'd16);
    cmp("full_last_word", 16'(last_word), 16'h10F);
    checkOutput("full_done", NOP, 0, 4'd15, 0, 1);
    n_extra = 0;
    for (int i = 0; i < 6; i++) begin
      idle_cycles(1, 0);
      if (bus.issue_valid) n_extra++;
    end
    cmp("full_no_wrap", 16'(n_extra), 16'd0);

    // Reset while waiting after the pc=3 issue
    $display("[TB] reset mid-wait");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle_cycles(9, 0);
    checkOutput("pc3_issue", 11'h103, 1, 4'd3, 1, 0);
    idle_cycles(1, 0);
    checkOutput("pc3_wait", NOP, 0, 4'd3, 1, 0);
    reset_n = 1'b0;
    idle_cycles(1, 0);
    checkOutput("mid_reset", NOP, 0, 4'd0, 0, 0);
    reset_n = 1'b1;

`ifdef CPU_SEQ_LOOP_EN
    // With loop set the 17th issue wraps back to address 0
    $display("[TB] loop wrap");
    bus.loop = 1;
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    n_issue = 1;
    for (int i = 0; i < 80 && n_issue < 17; i++) begin
      idle_cycles(1, 0);
      if (bus.issue_valid) begin
        n_issue++;
        if (n_issue == 17) checkOutput("loop_17th", 11'h100, 1, 4'd0, 1, 0);
      end
    end
    cmp("loop_reached_17", 16'(n_issue), 16'd17);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    bus.loop = 0;
`endif

    // Three-word program with last flag on the third word
    $display("[TB] free-run program");
    applyStimulus(1, 4'd0, 12'h005, 0, 0, 0, 0);
    applyStimulus(1, 4'd1, 12'h00A, 0, 0, 0, 0);
    applyStimulus(1, 4'd2, 12'h80F, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("run_c1", 11'h005, 1, 4'd0, 1, 0);
    idle_cycles(3, 0);
    checkOutput("run_c4", 11'h00A, 1, 4'd1, 1, 0);
    idle_cycles(3, 0);
    checkOutput("run_c7", 11'h00F, 1, 4'd2, 1, 0);
    idle_cycles(2, 0);
    checkOutput("run_c9", NOP, 0, 4'd2, 1, 0);
    idle_cycles(1, 0);
    checkOutput("run_c10", NOP, 0, 4'd2, 0, 1);

    // Single-step mode
    $display("[TB] step mode");
    applyStimulus(0, 0, 0, 1, 1, 0, 0);
    checkOutput("step_c1", 11'h005, 1, 4'd0, 1, 0);
    idle_cycles(3, 1);
    checkOutput("step_hold1", NOP, 0, 4'd1, 1, 0);
    idle_cycles(2, 1);
    checkOutput("step_hold1_still", NOP, 0, 4'd1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 1, 0);
    checkOutput("step_issue", 11'h00A, 1, 4'd1, 1, 0);
    idle_cycles(3, 1);
    checkOutput("step_hold2", NOP, 0, 4'd2, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkOutput("step_release", 11'h00F, 1, 4'd2, 1, 0);
    idle_cycles(3, 0);
    checkOutput("step_done", NOP, 0, 4'd2, 0, 1);

    // Abort and start together while waiting
    $display("[TB] abort with start");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle_cycles(1, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 1);
    checkOutput("abort", NOP, 0, 4'd0, 0, 0);
    n_extra = 0;
    for (int i = 0; i < 9; i++) begin
      idle_cycles(1, 0);
      if (bus.issue_valid) n_extra++;
    end
    cmp("abort_no_issue", 16'(n_extra), 16'd0);

    // Write while busy is dropped
    $display("[TB] write while busy");
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 4'd1, 12'h7FF, 0, 0, 0, 0);
    for (int i = 0; i < 40 && !bus.done; i++) idle_cycles(1, 0);
    cmp("busy_wr_done", 16'(bus.done), 16'd1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    idle_cycles(3, 0);
    checkOutput("busy_wr_kept", 11'h00A, 1, 4'd1, 1, 0);
    idle_cycles(6, 0);
    checkOutput("busy_wr_done2", NOP, 0, 4'd2, 0, 1);

    // Write together with start is dropped
    $display("[TB] write with start");
    applyStimulus(1, 4'd0, 12'h055, 1, 0, 0, 0);
    checkOutput("wr_start_old", 11'h005, 1, 4'd0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("wr_start_rerun", 11'h005, 1, 4'd0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    idle_cycles(2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
